// File: rtl/match_run_sched_if.sv
// match_run_sched_if: request, sample and window-report bundle for match_run_sched.
// hit_cnt exists only when MATCH_RUN_HITCNT_EN is defined.
interface match_run_sched_if;
    logic [3:0] req, a, b, gnt;
    logic busy, done, hit, abort;
    logic [1:0] done_id;
`ifdef MATCH_RUN_HITCNT_EN
    logic [31:0] hit_cnt;
`endif
    modport master (
        output req, a, b,
        input gnt, busy, done, hit, abort, done_id
`ifdef MATCH_RUN_HITCNT_EN
        , input hit_cnt
`endif
    );
    modport slave (
        input req, a, b,
        output gnt, busy, done, hit, abort, done_id
`ifdef MATCH_RUN_HITCNT_EN
        , output hit_cnt
`endif
    );
endinterface

// File: rtl/match_run_sched.sv
// match_run_sched: round-robin sharing of one equal-run detector among 4 channels.
// MATCH_RUN_HITCNT_EN adds per-channel saturating hit counters on bus.hit_cnt.
module match_run_sched #(
    parameter int RUN_LEN = 4,
    parameter int MAX_WIN = 16
) (
    input logic clk,
    input logic reset,
    match_run_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, ARB = 2'b01, RUN = 2'b11, REPORT = 2'b10} state_t;
    state_t state;
    logic [1:0] ptr, cur_id, win_id;
    logic [3:0] run_cnt;
    logic [7:0] win_cnt;
    logic eq, hit_now, to_now, keep;
    // Scan downward so the channel closest to ptr is assigned last and wins.
    always_comb begin
        win_id = ptr;
        for (int k = 3; k >= 0; k--) win_id = bus.req[ptr + 2'(k)] ? ptr + 2'(k) : win_id;
    end
    assign eq = bus.a[cur_id] == bus.b[cur_id];
    assign keep = bus.req[cur_id];
    assign hit_now = eq && run_cnt == 4'(RUN_LEN - 1);
    assign to_now = win_cnt == 8'(MAX_WIN - 1);
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bus.gnt <= '0;
            bus.done <= 1'b0;
            bus.hit <= 1'b0;
            bus.abort <= 1'b0;
            bus.done_id <= '0;
            ptr <= '0;
            cur_id <= '0;
            run_cnt <= '0;
            win_cnt <= '0;
        end else begin
            case (state)
                IDLE: state <= |bus.req ? ARB : IDLE;
                ARB: begin
                    if (|bus.req) begin
                        bus.gnt <= 4'b1 << win_id;
                        cur_id <= win_id;
                        run_cnt <= '0;
                        win_cnt <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (!keep || hit_now || to_now) begin
                        state <= REPORT;
                        bus.gnt <= '0;
                        bus.done <= 1'b1;
                        bus.hit <= keep && hit_now;
                        bus.abort <= !keep;
                        bus.done_id <= cur_id;
                        ptr <= cur_id + 2'd1;
                    end else begin
                        run_cnt <= eq ? run_cnt + 4'd1 : '0;
                        win_cnt <= win_cnt + 8'd1;
                    end
                end
                REPORT: begin
                    bus.done <= 1'b0;
                    bus.hit <= 1'b0;
                    bus.abort <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`ifdef MATCH_RUN_HITCNT_EN
    logic [7:0] cur_hits;
    assign cur_hits = bus.hit_cnt[{cur_id, 3'b000} +: 8];
    always_ff @(posedge clk) begin
        if (reset) bus.hit_cnt <= '0;
        else if (state == RUN && keep && hit_now && cur_hits != 8'hff)
            bus.hit_cnt[{cur_id, 3'b000} +: 8] <= cur_hits + 8'd1;
    end
`endif
endmodule
